pipe_ctrl_chain: RTL and testbench

PIPE_CTRL_CHAIN -- requirements
Module: pipe_ctrl_chain

---
 rtl/pipe_ctrl_chain_pkg.sv | 13 +
 rtl/pipe_ctrl_chain_if.sv | 41 ++++
 rtl/pipe_ctrl_chain_stage.sv | 39 +++
 rtl/pipe_ctrl_chain.sv | 99 +++++++++
 tb/tb_pipe_ctrl_chain.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_chain_pkg.sv
// Shared constants and stage-entry layout for the control pipeline chain.
package pipe_pkg;
  localparam int XZR       = 31;
  localparam int DEF_REGW  = 5;
  localparam int DEF_WIDTH = 64;

  typedef struct packed {
    logic                 valid;
    logic                 wr;
    logic [DEF_REGW-1:0]  rd;
    logic [DEF_WIDTH-1:0] data;
  } stage_entry_t;
endpackage

// File: rtl/pipe_ctrl_chain_if.sv
// Handshake, control and observation signals of the pipeline chain.
interface pipe_ctrl_chain_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int REGW  = 5
);
  localparam int SW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [REGW-1:0]  in_rd;
  logic             in_wr;
  logic             in_ready;
  logic [DEPTH-1:0] stall_req;
  logic             flush;
  logic [SW-1:0]    flush_stage;
  logic [REGW-1:0]  Aa;
  logic [REGW-1:0]  Ab;
  logic [CW-1:0]    fwdA;
  logic [CW-1:0]    fwdB;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [REGW-1:0]  out_rd;
  logic             out_wr;
  logic [DEPTH-1:0] stage_valid;
  logic [CW-1:0]    occupancy;
  logic [31:0]      stall_cycles;

  modport master (
    output in_valid, in_data, in_rd, in_wr, stall_req, flush, flush_stage, Aa, Ab,
    input  in_ready, fwdA, fwdB, out_valid, out_data, out_rd, out_wr,
           stage_valid, occupancy, stall_cycles
  );

  modport slave (
    input  in_valid, in_data, in_rd, in_wr, stall_req, flush, flush_stage, Aa, Ab,
    output in_ready, fwdA, fwdB, out_valid, out_data, out_rd, out_wr,
           stage_valid, occupancy, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl_chain_stage.sv
// One pipeline entry register: clear beats hold, hold beats bubble, bubble beats load.
module pipe_stage import pipe_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int REGW  = DEF_REGW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             bubble,
  input  logic             clear,
  input  logic             ld_valid,
  input  logic             ld_wr,
  input  logic [REGW-1:0]  ld_rd,
  input  logic [WIDTH-1:0] ld_data,
  output logic             q_valid,
  output logic             q_wr,
  output logic [REGW-1:0]  q_rd,
  output logic [WIDTH-1:0] q_data
);
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_valid <= 1'b0;
      q_wr    <= 1'b0;
      q_rd    <= '0;
      q_data  <= '0;
    end else begin
      if (clear || (bubble && !hold))
        q_valid <= 1'b0;
      else if (!hold)
        q_valid <= ld_valid;
      // Payload of a bubble is left stale; only the valid bit matters.
      if (!hold && !bubble) begin
        q_wr   <= ld_wr;
        q_rd   <= ld_rd;
        q_data <= ld_data;
      end
    end
  end
endmodule

// File: rtl/pipe_ctrl_chain.sv
// In-order pipeline chain with per-stage stall, partial flush and register forwarding lookup.
module pipe_ctrl_chain import pipe_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 4,
  parameter int REGW  = DEF_REGW
) (
  input logic clk,
  input logic reset,
  pipe_ctrl_chain_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] hold, bubble, clear;
  logic [DEPTH-1:0] sv, sw;
  logic [REGW-1:0]  srd  [DEPTH];
  logic [WIDTH-1:0] sdat [DEPTH];
  logic             in_ready_c;
  logic [CW-1:0]    occ, fwd_a, fwd_b;
  logic [31:0]      stall_cnt_q;

  assign in_ready_c = (bus.stall_req == '0);

  // A stage holds when it or any older stage requests a stall.
  always_comb begin
    hold   = '0;
    bubble = '0;
    clear  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hold[i]  = |(bus.stall_req >> i);
      clear[i] = bus.flush && (i <= int'(bus.flush_stage));
    end
    for (int i = 1; i < DEPTH; i++)
      bubble[i] = hold[i-1] && !hold[i];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             l_valid, l_wr;
    logic [REGW-1:0]  l_rd;
    logic [WIDTH-1:0] l_data;
    if (i == 0) begin : g_head
      assign l_valid = bus.in_valid && in_ready_c;
      assign l_wr    = bus.in_wr;
      assign l_rd    = bus.in_rd;
      assign l_data  = bus.in_data;
    end else begin : g_body
      assign l_valid = sv[i-1];
      assign l_wr    = sw[i-1];
      assign l_rd    = srd[i-1];
      assign l_data  = sdat[i-1];
    end
    pipe_stage #(.WIDTH(WIDTH), .REGW(REGW)) u_stage (
      .clk     (clk),
      .reset   (reset),
      .hold    (hold[i]),
      .bubble  (bubble[i]),
      .clear   (clear[i]),
      .ld_valid(l_valid),
      .ld_wr   (l_wr),
      .ld_rd   (l_rd),
      .ld_data (l_data),
      .q_valid (sv[i]),
      .q_wr    (sw[i]),
      .q_rd    (srd[i]),
      .q_data  (sdat[i])
    );
  end

  // Scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    occ   = '0;
    fwd_a = '0;
    fwd_b = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      occ = occ + CW'(sv[i]);
      if (sv[i] && sw[i] && srd[i] == bus.Aa) fwd_a = CW'(i + 1);
      if (sv[i] && sw[i] && srd[i] == bus.Ab) fwd_b = CW'(i + 1);
    end
    if (bus.Aa == REGW'(XZR)) fwd_a = '0;
    if (bus.Ab == REGW'(XZR)) fwd_b = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset)
      stall_cnt_q <= '0;
    else if ((bus.stall_req != '0) && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.fwdA         = fwd_a;
  assign bus.fwdB         = fwd_b;
  assign bus.out_valid    = sv[DEPTH-1];
  assign bus.out_wr       = sw[DEPTH-1];
  assign bus.out_rd       = srd[DEPTH-1];
  assign bus.out_data     = sdat[DEPTH-1];
  assign bus.stage_valid  = sv;
  assign bus.occupancy    = occ;
  assign bus.stall_cycles = stall_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Random and directed stimulus against an array-level reference model with a retirement scoreboard.
module tb_pipe_ctrl_chain;
  import pipe_pkg::*;
  localparam int W = 64, D = 4, R = 5;

  typedef struct {
    logic         rst, iv, wr, fl;
    logic [W-1:0] d;
    logic [R-1:0] rd, a, b;
    logic [D-1:0] st;
    logic [1:0]   fs;
  } stim_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_ctrl_chain_if #(.WIDTH(W), .DEPTH(D), .REGW(R)) bus ();
  pipe_ctrl_chain #(.WIDTH(W), .DEPTH(D), .REGW(R)) dut (.clk(clk), .reset(reset), .bus(bus));

  stage_entry_t m [D];
  stage_entry_t exp_q [$];
  logic [31:0]  m_stall;
  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_fwd(input logic [R-1:0] a);
    if (a == 5'd31) return 0;
    for (int i = 0; i < D; i++)
      if (m[i].valid && m[i].wr && m[i].rd == a) return i + 1;
    return 0;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b1; s.iv = 1'b0; s.wr = 1'b0; s.fl = 1'b0;
    s.d = '0; s.rd = '0; s.a = '0; s.b = '0; s.st = '0; s.fs = '0;
    return s;
  endfunction

  task automatic model_step(input stim_t s);
    stage_entry_t nm [D];
    int h;
    if (!s.rst) begin
      for (int i = 0; i < D; i++) m[i] = '0;
      exp_q.delete();
      m_stall = '0;
      return;
    end
    if (m[D-1].valid && !s.st[D-1]) exp_q.push_back(m[D-1]);
    h = -1;
    for (int i = 0; i < D; i++) if (s.st[i]) h = i;
    for (int i = 0; i < D; i++) begin
      if (i <= h) nm[i] = m[i];
      else if (h >= 0 && i == h + 1) begin nm[i] = m[i]; nm[i].valid = 1'b0; end
      else if (i == 0) begin
        nm[i].valid = s.iv && (s.st == '0);
        nm[i].wr = s.wr; nm[i].rd = s.rd; nm[i].data = s.d;
      end
      else nm[i] = m[i-1];
      if (s.fl && i <= int'(s.fs)) nm[i].valid = 1'b0;
    end
    m = nm;
    if (s.st != '0 && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
  endtask

  // One cycle: check registered state, drive inputs, check combinational outputs, advance model.
  task automatic step(input stim_t s);
    logic [D-1:0] mv;
    @(negedge clk);
    for (int i = 0; i < D; i++) mv[i] = m[i].valid;
    check("stage_valid", 64'(bus.stage_valid), 64'(mv));
    check("occupancy", 64'(bus.occupancy), 64'($countones(mv)));
    check("stall_cycles", 64'(bus.stall_cycles), 64'(m_stall));
    reset = s.rst; bus.in_valid = s.iv; bus.in_data = s.d; bus.in_rd = s.rd; bus.in_wr = s.wr;
    bus.stall_req = s.st; bus.flush = s.fl; bus.flush_stage = s.fs; bus.Aa = s.a; bus.Ab = s.b;
    #1;
    check("in_ready", 64'(bus.in_ready), 64'(s.st == '0));
    check("fwdA", 64'(bus.fwdA), 64'(ref_fwd(s.a)));
    check("fwdB", 64'(bus.fwdB), 64'(ref_fwd(s.b)));
    model_step(s);
  endtask

  task automatic push_entry(input logic [W-1:0] d, input logic [R-1:0] rd, input logic wr);
    stim_t s = idle();
    s.iv = 1'b1; s.d = d; s.rd = rd; s.wr = wr;
    step(s);
  endtask

  task automatic drain();
    for (int i = 0; i < D + 1; i++) step(idle());
  endtask

  // Probe the lookup against the current registers without spending a cycle.
  task automatic peek_fwd(input string name, input logic [R-1:0] a, input int exp);
    bus.Aa = a;
    #1;
    check(name, 64'(bus.fwdA), 64'(exp));
  endtask

  // Scoreboard monitor: pops an expected entry on every DUT retirement.
  initial begin
    stage_entry_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset && bus.out_valid && !bus.stall_req[D-1]) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL retire_unexpected: got data %h expected no retirement", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", bus.out_data, e.data);
          check("out_rd", 64'(bus.out_rd), 64'(e.rd));
          check("out_wr", 64'(bus.out_wr), 64'(e.wr));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    int peak;
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_rd = '0; bus.in_wr = 1'b0;
    bus.stall_req = '0; bus.flush = 1'b0; bus.flush_stage = '0; bus.Aa = '0; bus.Ab = '0;
    for (int i = 0; i < D; i++) m[i] = '0;
    m_stall = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_out_rd", 64'(bus.out_rd), 64'd0);

    // Stream six entries with no stall.
    peak = 0;
    for (int k = 0; k < 6; k++) begin
      push_entry(64'(100 + k), R'(k), 1'b1);
      if (int'(bus.occupancy) > peak) peak = int'(bus.occupancy);
    end
    for (int k = 0; k < D + 1; k++) begin
      step(idle());
      if (int'(bus.occupancy) > peak) peak = int'(bus.occupancy);
    end
    check("peak_occupancy", 64'(peak), 64'd4);

    // Stall at stage 1 for two cycles on a full pipe.
    for (int k = 0; k < D; k++) push_entry(64'(200 + k), R'(k), 1'b1);
    s = idle(); s.iv = 1'b1; s.d = 64'hDEAD; s.st = 4'b0010;
    step(s);
    check("stall_in_ready", 64'(bus.in_ready), 64'd0);
    step(s);
    step(idle());
    check("stall_count_2", 64'(bus.stall_cycles), 64'd2);
    drain();

    // Forwarding: youngest producer wins, invalid stage skipped, XZR never forwards.
    push_entry(64'h1, 5'd3, 1'b1);
    push_entry(64'h2, 5'd31, 1'b1);
    push_entry(64'h3, 5'd3, 1'b1);
    s = idle(); s.st = 4'b1111;
    step(s);
    peek_fwd("fwd_youngest", 5'd3, 1);
    s.fl = 1'b1; s.fs = 2'd0;
    step(s);
    s.fl = 1'b0;
    step(s);
    peek_fwd("fwd_skip_invalid", 5'd3, 3);
    peek_fwd("fwd_xzr", 5'd31, 0);
    drain();

    // Partial flush with a simultaneous offered entry.
    for (int k = 0; k < D; k++) push_entry(64'(300 + k), R'(k), 1'b0);
    s = idle(); s.iv = 1'b1; s.d = 64'hBEEF; s.fl = 1'b1; s.fs = 2'd1;
    step(s);
    step(idle());
    check("flush_valid", 64'(bus.stage_valid), 64'(4'b1100));
    check("flush_occ", 64'(bus.occupancy), 64'd2);
    drain();

    // Reset with a full, stalled pipe, then saturate the stall counter.
    for (int k = 0; k < D; k++) push_entry(64'(400 + k), R'(k), 1'b1);
    s = idle(); s.st = 4'b0100;
    step(s);
    s.rst = 1'b0; s.iv = 1'b1; s.fl = 1'b1;
    step(s);
    step(idle());
    check("rst_mid_valid", 64'(bus.stage_valid), 64'd0);
    check("rst_mid_occ", 64'(bus.occupancy), 64'd0);
    check("rst_mid_stall", 64'(bus.stall_cycles), 64'd0);
    check("rst_mid_data", bus.out_data, 64'd0);
    #1;
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    m_stall = 32'hFFFF_FFFD;
    s = idle(); s.st = 4'b0001;
    repeat (4) step(s);
    step(idle());
    check("stall_saturate", 64'(bus.stall_cycles), 64'hFFFF_FFFF);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      s.rst = ($urandom_range(0, 60) != 0);
      s.iv  = ($urandom_range(0, 3) != 0);
      s.d   = {$urandom, $urandom};
      s.rd  = ($urandom_range(0, 7) == 0) ? 5'd31 : R'($urandom_range(0, 7));
      s.wr  = ($urandom_range(0, 3) != 0);
      s.st  = ($urandom_range(0, 3) == 0) ? D'($urandom) : '0;
      s.fl  = ($urandom_range(0, 9) == 0);
      s.fs  = 2'($urandom);
      s.a   = ($urandom_range(0, 7) == 0) ? 5'd31 : R'($urandom_range(0, 7));
      s.b   = R'($urandom_range(0, 7));
      step(s);
    end
    drain();
    step(idle());
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
